// File: rtl/mux2x1_arb.sv
// Round-robin arbiter for two requesters driving a shared 2:1 mux, with a bounded
// hold time under contention and a registered copy of the owning channel's data.
module mux2x1_arb #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [2*WIDTH-1:0] din,
    output logic [1:0]         gnt,
    output logic               sel,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_vld
);

    localparam int unsigned    CW      = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               sel_q, sel_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               vld_q, vld_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                case (req)
                    2'b01:   state_d = OWN0;
                    2'b10:   state_d = OWN1;
                    2'b11:   state_d = last_q ? OWN0 : OWN1;
                    default: state_d = IDLE;
                endcase
            end
            OWN0: begin
                if (!req[0])
                    state_d = req[1] ? OWN1 : IDLE;
                else if (req[1] && (cnt_q == CNT_MAX))
                    state_d = OWN1;
            end
            OWN1: begin
                if (!req[1])
                    state_d = req[0] ? OWN0 : IDLE;
                else if (req[0] && (cnt_q == CNT_MAX))
                    state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts on any new grant and saturates while the owner is retained.
        if ((state_d != IDLE) && (state_d == state_q))
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        if (state_d == OWN0) begin
            last_d = 1'b0;
            sel_d  = 1'b0;
        end else if (state_d == OWN1) begin
            last_d = 1'b1;
            sel_d  = 1'b1;
        end

        gnt_d = {state_d == OWN1, state_d == OWN0};
    end

    always_comb begin
        dout_d = dout_q;
        vld_d  = 1'b0;
        case (state_q)
            OWN0: begin
                dout_d = din[WIDTH-1:0];
                vld_d  = 1'b1;
            end
            OWN1: begin
                dout_d = din[2*WIDTH-1:WIDTH];
                vld_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign dout     = dout_q;
    assign dout_vld = vld_q;

endmodule

// File: tb/tb_mux2x1_arb.sv
// Directed bench for mux2x1_arb (WIDTH=4, MAX_HOLD=4) with hand-computed expectations.
module tb_mux2x1_arb;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] din;
    logic [1:0] gnt;
    logic       sel;
    logic [3:0] dout;
    logic       dout_vld;

    int errors = 0;
    int checks = 0;

    mux2x1_arb #(.WIDTH(4), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .sel      (sel),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_sel"}, 32'(sel), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_vld"}, 32'(dout_vld), 32'd0);
    endtask

    initial begin
        logic [1:0] eg;
        logic [3:0] ed;
        logic       ev;

        // Reset held with both requests up
        rst_n = 1'b0;
        req   = 2'b11;
        din   = {4'h5, 4'hA};
        #12;
        check_cleared("rst");

        // Tie and preemption: 4 cycles each, data lags grant by one cycle
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            eg = (i <= 4) ? 2'b01 : (i <= 8) ? 2'b10 : 2'b01;
            ed = (i == 1) ? 4'h0 : (i <= 5) ? 4'hA : (i <= 9) ? 4'h5 : 4'hA;
            ev = (i != 1);
            check($sformatf("tie_gnt%0d", i), 32'(gnt), 32'(eg));
            check($sformatf("tie_sel%0d", i), 32'(sel), 32'(eg[1]));
            check($sformatf("tie_dout%0d", i), 32'(dout), 32'(ed));
            check($sformatf("tie_vld%0d", i), 32'(dout_vld), 32'(ev));
        end
        tick();
        check("tie_gnt13", 32'(gnt), 32'b10);
        check("tie_sel13", 32'(sel), 32'd1);

        // Asynchronous reset in the middle of an OWN1 grant
        #3;
        rst_n = 1'b0;
        #1;
        check_cleared("async_rst");

        // Single request on channel 0
        req = 2'b01;
        din = {4'h0, 4'hA};
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("single_gnt", 32'(gnt), 32'b01);
        check("single_sel", 32'(sel), 32'd0);
        check("single_vld0", 32'(dout_vld), 32'd0);
        tick();
        check("single_dout", 32'(dout), 32'hA);
        check("single_vld1", 32'(dout_vld), 32'd1);
        req = 2'b00;
        tick();
        check("release_gnt", 32'(gnt), 32'b00);
        check("release_vld", 32'(dout_vld), 32'd1);
        tick();
        check("release_vld0", 32'(dout_vld), 32'd0);
        check("release_dout", 32'(dout), 32'hA);
        check("release_sel", 32'(sel), 32'd0);

        // Handoff from OWN0 at cnt=1 without an idle cycle
        req = 2'b01;
        tick();
        check("ho_own0", 32'(gnt), 32'b01);
        req = 2'b11;
        tick();
        check("ho_hold", 32'(gnt), 32'b01);
        req = 2'b10;
        din = {4'h3, 4'hC};
        tick();
        check("ho_gnt", 32'(gnt), 32'b10);
        check("ho_sel", 32'(sel), 32'd1);
        req = 2'b11;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("ho_keep%0d", i), 32'(gnt), 32'b10);
        end
        check("ho_dout", 32'(dout), 32'h3);
        tick();
        check("ho_back", 32'(gnt), 32'b01);

        // Round-robin memory: channel 1 last owner, then tie goes to 0
        req = 2'b10;
        tick();
        check("rr_own1", 32'(gnt), 32'b10);
        req = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("rr_idle%0d", i), 32'(gnt), 32'b00);
        end
        check("rr_sel_hold", 32'(sel), 32'd1);
        req = 2'b11;
        tick();
        check("rr_tie0", 32'(gnt), 32'b01);
        req = 2'b00;
        for (int i = 1; i <= 3; i++) tick();
        check("rr_idle_b", 32'(gnt), 32'b00);
        check("rr_sel_hold0", 32'(sel), 32'd0);
        req = 2'b11;
        tick();
        check("rr_tie1", 32'(gnt), 32'b10);

        // Saturation: lone owner for 10 cycles, preempted on the first edge after req[1]
        req = 2'b00;
        tick();
        check("sat_idle", 32'(gnt), 32'b00);
        req = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("sat_hold%0d", i), 32'(gnt), 32'b01);
        end
        req = 2'b11;
        tick();
        check("sat_preempt", 32'(gnt), 32'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
